// File: rtl/unidade_load_store_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// The slave modport is the unit; the master modport is the pipeline plus the memory model.
interface unidade_load_store_if;
    logic        START;
    logic [4:0]  OP;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] RDATA;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;

    // Handshake: MEM_REQ holds with stable MEM_* until a cycle with MEM_ACK=1; ACK without REQ is ignored.
    modport master (
        output START, OP, ADDR, WDATA, MEM_ACK, MEM_RDATA,
        input  BUSY, DONE, ERR, RDATA, MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA
    );
    modport slave (
        input  START, OP, ADDR, WDATA, MEM_ACK, MEM_RDATA,
        output BUSY, DONE, ERR, RDATA, MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/unidade_load_store.sv
// Multi-cycle MIPS load/store unit: IDLE -> REQ -> RESP with byte-lane steering and timeout.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module unidade_load_store #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    unidade_load_store_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;
    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;

    logic        is_byte, is_half, is_word, is_store, op_legal, misaligned, start_ok, timeout;
    logic [3:0]  be_gen;
    logic [31:0] wdata_gen, load_data;

    always_comb begin
        is_byte  = (bus.OP == 5'd12) || (bus.OP == 5'd15);
        is_half  = (bus.OP == 5'd13) || (bus.OP == 5'd16);
        is_word  = (bus.OP == 5'd14) || (bus.OP == 5'd17);
        is_store = (bus.OP == 5'd15) || (bus.OP == 5'd16) || (bus.OP == 5'd17);
        op_legal = is_byte || is_half || is_word;
`ifdef LSU_ALIGN_CHECK_EN
        misaligned = (is_half && bus.ADDR[0]) || (is_word && (bus.ADDR[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        start_ok  = op_legal && !misaligned;
        be_gen    = 4'b1111;
        wdata_gen = bus.WDATA;
        if (is_byte) begin
            be_gen    = 4'b0001 << bus.ADDR[1:0];
            wdata_gen = {4{bus.WDATA[7:0]}};
        end else if (is_half) begin
            be_gen    = bus.ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_gen = {2{bus.WDATA[15:0]}};
        end
        timeout = (cnt_q == CNT_LAST);
    end

    // Load extraction uses the lane/size captured on REQ entry, not the live inputs.
    always_comb begin
        load_data = bus.MEM_RDATA;
        if (size_q == 2'd0)
            load_data = {24'b0, bus.MEM_RDATA[{lane_q, 3'b000} +: 8]};
        else if (size_q == 2'd1)
            load_data = {16'b0, lane_q[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.START) state_d = start_ok ? S_REQ : S_RESP;
            S_REQ:   if (bus.MEM_ACK || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY      = (state_q != S_IDLE);
        bus.DONE      = (state_q == S_RESP);
        bus.ERR       = (state_q == S_RESP) && err_q;
        bus.MEM_REQ   = (state_q == S_REQ);
        bus.MEM_WE    = we_q;
        bus.MEM_BE    = be_q;
        bus.MEM_ADDR  = addr_q;
        bus.MEM_WDATA = wdata_q;
        bus.RDATA     = rdata_q;
        dbg_state_o   = state_q;
    end

    // On ACK at the timeout edge the ACK branch is taken first, so ERR stays 0.
    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        size_d  = size_q;
        if (state_q == S_IDLE && bus.START) begin
            err_d = !start_ok;
            cnt_d = 8'd0;
            if (start_ok) begin
                we_d    = is_store;
                be_d    = be_gen;
                addr_d  = {bus.ADDR[31:2], 2'b00};
                wdata_d = wdata_gen;
                lane_d  = bus.ADDR[1:0];
                size_d  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
            end
        end else if (state_q == S_REQ) begin
            if (bus.MEM_ACK) begin
                err_d = 1'b0;
                if (!we_q) rdata_d = load_data;
            end else if (timeout) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
        end
    end
endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Multi-cycle load/store unit for the 32-bit MIPS datapath, on the consuming side of the ULA address path. It takes the ULA memory op code (12–17) and the effective byte address, then runs a request/acknowledge transaction with data memory. For stores it performs byte-lane steering; for loads it extracts and zero-extends the addressed lanes. It stalls the pipeline through `BUSY` and ends every operation with a one-cycle `DONE` pulse.

## Interface
- `WAIT_MAX`, default 15: cycles `MEM_REQ` may stay high without `MEM_ACK` before timeout (1..255).
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: operation request, sampled only in IDLE.
- `OP` in 5: ULA op code. 12 LBU, 13 LHU, 14 LW, 15 SB, 16 SH, 17 SW; any other value is illegal.
- `ADDR` in 32: effective byte address (full base+offset sum, unmasked).
- `WDATA` in 32: store data, low bits significant for SB/SH.
- `BUSY` out 1: high whenever state ≠ IDLE.
- `DONE` out 1: one-cycle completion pulse.
- `ERR` out 1: valid with `DONE`; marks illegal op, misalignment or timeout.
- `RDATA` out 32: load result, held until the next `DONE`.
- `MEM_REQ` out 1: memory request.
- `MEM_WE` out 1: 1 = write.
- `MEM_BE` out 4: byte enables, little-endian lanes.
- `MEM_ADDR` out 32: word address, `{ADDR[31:2],2'b00}`.
- `MEM_WDATA` out 32: lane-steered store data.
- `MEM_ACK` in 1: memory accepts the write or returns read data, single cycle.
- `MEM_RDATA` in 32: read data, valid with `MEM_ACK`.

## Operation
- States: IDLE, REQ, RESP.
  - IDLE → REQ on `START` with a legal, aligned op.
  - IDLE → RESP (ERR=1) on `START` with an illegal or misaligned op. No memory request is issued.
  - REQ → RESP on `MEM_ACK`, or on timeout (ERR=1).
  - RESP → IDLE, always.
- `OP`, `ADDR` and `WDATA` are registered on entry to REQ. Memory outputs are driven from these registers and stay stable while `MEM_REQ` is high.
- Byte-enable generation:
  - Byte ops: `MEM_BE = 4'b0001 << ADDR[1:0]`; `MEM_WDATA = {4{WDATA[7:0]}}`.
  - Half ops: `MEM_BE = ADDR[1] ? 4'b1100 : 4'b0011`; `MEM_WDATA = {2{WDATA[15:0]}}`.
  - Word ops: `MEM_BE = 4'b1111`; `MEM_WDATA = WDATA`.
- Loads:
  - `MEM_WE = 0`; `MEM_BE` is generated exactly as for stores.
  - LBU: `RDATA = {24'b0, lane selected by ADDR[1:0]}`.
  - LHU: `RDATA = {16'b0, half selected by ADDR[1]}`.
  - LW: `RDATA = MEM_RDATA`.
- Stores: `MEM_WE = 1`. `RDATA` is left unchanged.
- Error cases:
  - On any error `RDATA` is left unchanged.
  - Timeout: a counter clears on REQ entry and increments each REQ cycle without `MEM_ACK`. When it reaches `WAIT_MAX`, `MEM_REQ` drops and the FSM moves to RESP with ERR=1.
  - If `MEM_ACK` arrives in the same cycle the counter reaches `WAIT_MAX`, the ACK wins and ERR=0.
- `START` while `BUSY` is ignored.
- `MEM_ACK` while `MEM_REQ` is low is ignored.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0, including `RDATA`, `MEM_BE`, `MEM_ADDR`, `MEM_WDATA`.
- Reset during REQ drops `MEM_REQ` at once; the transaction is abandoned and produces no `DONE`.
- `START` at edge t:
  - `MEM_REQ` is high from cycle t+1; all memory outputs are registered.
  - `MEM_ACK` sampled at edge k → `DONE`/`RDATA` valid during cycle k+1, and `MEM_REQ` is low in k+1.
  - Minimum latency with ACK in the first REQ cycle: `DONE` 2 cycles after `START`.
- Error path (illegal op or misalignment): `DONE`+`ERR` in cycle t+1.
- Next `START` is accepted at the earliest one cycle after `DONE`. Minimum issue interval is 3 cycles.
- `BUSY` is combinational from state and is high in the `DONE` cycle.

## Configuration
- `LSU_ALIGN_CHECK_EN`, defined:
  - LHU/SH with `ADDR[0]=1` is an error.
  - LW/SW with `ADDR[1:0]≠0` is an error.
  - Both go to RESP with ERR=1 and no memory request.
- `LSU_ALIGN_CHECK_EN`, undefined:
  - No alignment check.
  - Half ops ignore `ADDR[0]`; word ops ignore `ADDR[1:0]`.
  - Misalignment never raises ERR.

## Test plan
- SB: `OP=15`, `ADDR=0x1003`, `WDATA=0xAABBCCDD`, ACK in the first REQ cycle.
  - Required: `MEM_ADDR=0x1000`, `MEM_BE=1000`, `MEM_WDATA=0xDDDDDDDD`, `MEM_WE=1`.
  - Required: `DONE` 2 cycles after `START`, ERR=0.
- LHU: `OP=13`, `ADDR=0x2002`, `MEM_RDATA=0x8765_4321`, ACK after 3 wait cycles.
  - Required: `MEM_BE=1100`, `RDATA=0x00008765`, `DONE` 5 cycles after `START`.
- LW timeout: `OP=14`, `ADDR=0x40`, no ACK, `WAIT_MAX=15`.
  - Required: `MEM_REQ` high for exactly 15 cycles, then `DONE`+`ERR`, `RDATA` unchanged.
  - Repeat with ACK on the 15th cycle → ERR=0.
- Illegal op `OP=2` with `START`.
  - Required: `DONE`+`ERR` next cycle, `MEM_REQ` never rises.
  - Required: `START` pulses during `BUSY` are ignored.
- Misaligned SW `ADDR=0x102`.
  - With `LSU_ALIGN_CHECK_EN`: ERR, no request.
  - Without: `MEM_ADDR=0x100`, `MEM_BE=1111`, ERR=0.
- Reset mid-op: deassert `RST_N` in the 2nd REQ cycle.
  - Required: `MEM_REQ`, `BUSY` and `RDATA` go to 0 immediately, no `DONE`.
  - Required: after release, a new LBU completes normally.
